// File: rtl/rcc_ppre_update_ctrl.sv
// APB/timer prescaler update controller: defers ratio changes to a
// divider period boundary, with settle window, done pulse and timeout.
module rcc_ppre_update_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int TMO_CYC    = 32
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [2:0] wr_ppre,
  input  logic       wr_timpre,
  input  logic       div_en,
  input  logic       err_clr,
  output logic [2:0] div_sel,
  output logic       timpre,
  output logic       busy,
  output logic       upd_done,
  output logic       tmo_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BND,
    HOLD,
    DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  localparam logic [3:0] SET_LAST = 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] tgt_q, tgt_d;
  logic [3:0] pend_q, pend_d;
  logic       pend_v_q, pend_v_d;
  logic [7:0] tmo_q, tmo_d;
  logic [3:0] set_q, set_d;
  logic [3:0] out_d;
  logic       err_d;
  logic       done_d;
  logic [3:0] wr_val;
  logic [3:0] cur;

  assign wr_val = {wr_timpre, wr_ppre};
  assign cur    = {timpre, div_sel};

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    tmo_d    = tmo_q;
    set_d    = set_q;
    out_d    = cur;
    err_d    = tmo_err;
    done_d   = 1'b0;

    if (err_clr)
      err_d = 1'b0;

    // Writes outside IDLE land in the one-deep slot; newest wins.
    if (wr_req && state_q != IDLE) begin
      pend_d   = wr_val;
      pend_v_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          if (wr_val != cur) begin
            tgt_d   = wr_val;
            tmo_d   = 8'd0;
            state_d = WAIT_BND;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_BND: begin
        tmo_d = tmo_q + 8'd1;
        if (div_en || tmo_q == TMO_LAST) begin
          out_d   = tgt_q;
          tmo_d   = 8'd0;
          set_d   = 4'd0;
          state_d = HOLD;
          if (!div_en)
            err_d = 1'b1;
        end
      end
      HOLD: begin
        if (set_q == SET_LAST)
          state_d = DONE;
        else
          set_d = set_q + 4'd1;
      end
      DONE: begin
        if (pend_v_d) begin
          tgt_d    = pend_d;
          pend_d   = 4'd0;
          pend_v_d = 1'b0;
          tmo_d    = 8'd0;
          state_d  = WAIT_BND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE)
      done_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tgt_q    <= 4'd0;
      pend_q   <= 4'd0;
      pend_v_q <= 1'b0;
      tmo_q    <= 8'd0;
      set_q    <= 4'd0;
      div_sel  <= 3'b000;
      timpre   <= 1'b0;
      busy     <= 1'b0;
      upd_done <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      tmo_q    <= tmo_d;
      set_q    <= set_d;
      {timpre, div_sel} <= out_d;
      busy     <= (state_d != IDLE);
      upd_done <= done_d;
      tmo_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_rcc_ppre_update_ctrl.sv
// Directed bench for rcc_ppre_update_ctrl with an expected-apply queue
// that is drained on every upd_done pulse.
module tb_rcc_ppre_update_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_req = 1'b0;
  logic [2:0] wr_ppre = 3'b000;
  logic       wr_timpre = 1'b0;
  logic       div_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] div_sel;
  logic       timpre;
  logic       busy;
  logic       upd_done;
  logic       tmo_err;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  logic [3:0] q[$];

  rcc_ppre_update_ctrl #(.SETTLE_CYC(2), .TMO_CYC(32)) dut (
    .i_clk    (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_ppre  (wr_ppre),
    .wr_timpre(wr_timpre),
    .div_en   (div_en),
    .err_clr  (err_clr),
    .div_sel  (div_sel),
    .timpre   (timpre),
    .busy     (busy),
    .upd_done (upd_done),
    .tmo_err  (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (upd_done) begin
      n_done++;
      chk("done_expected", 8'(q.size() != 0), 8'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("done_val", {4'd0, timpre, div_sel}, {4'd0, e});
      end
    end
  endtask

  task automatic wait_done(input string tag, input int n);
    logic got;
    got = 1'b0;
    for (int i = 0; i < n && !got; i++) begin
      step();
      if (upd_done) got = 1'b1;
    end
    chk(tag, 8'(got), 8'd1);
  endtask

  task automatic write(input logic [2:0] p, input logic t);
    wr_req    = 1'b1;
    wr_ppre   = p;
    wr_timpre = t;
  endtask

  initial begin
    int base;
    step();
    step();
    chk("rst_div_sel", 8'(div_sel), 8'h0);
    chk("rst_timpre", 8'(timpre), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_done", 8'(upd_done), 8'h0);
    chk("rst_err", 8'(tmo_err), 8'h0);
    rst = 1'b0;
    step();

    // same-value write
    write(3'b000, 1'b0);
    q.push_back(4'b0000);
    step();
    wr_req = 1'b0;
    chk("same_done", 8'(upd_done), 8'h1);
    chk("same_busy", 8'(busy), 8'h0);
    step();
    chk("same_busy2", 8'(busy), 8'h0);
    chk("same_done_end", 8'(upd_done), 8'h0);
    chk("same_sel", 8'(div_sel), 8'h0);

    // basic update, div_en at t+5
    write(3'b101, 1'b0);
    q.push_back(4'b0101);
    step();
    wr_req = 1'b0;
    chk("upd_busy_t1", 8'(busy), 8'h1);
    for (int i = 0; i < 4; i++) step();
    chk("upd_sel_t5", 8'(div_sel), 8'h0);
    div_en = 1'b1;
    step();
    div_en = 1'b0;
    chk("upd_sel_t6", 8'(div_sel), 8'h5);
    step();
    chk("upd_done_t7", 8'(upd_done), 8'h0);
    step();
    chk("upd_done_t8", 8'(upd_done), 8'h1);
    chk("upd_busy_t8", 8'(busy), 8'h1);
    step();
    chk("upd_busy_t9", 8'(busy), 8'h0);

    // pending overwrite
    base = n_done;
    write(3'b100, 1'b0);
    q.push_back(4'b0100);
    step();
    write(3'b110, 1'b0);
    step();
    write(3'b111, 1'b0);
    q.push_back(4'b0111);
    step();
    wr_req = 1'b0;
    step();
    div_en = 1'b1;
    step();
    div_en = 1'b0;
    chk("pend_first", 8'(div_sel), 8'h4);
    wait_done("pend_done1", 6);
    step();
    chk("pend_busy", 8'(busy), 8'h1);
    chk("pend_hold_sel", 8'(div_sel), 8'h4);
    div_en = 1'b1;
    step();
    div_en = 1'b0;
    chk("pend_second", 8'(div_sel), 8'h7);
    wait_done("pend_done2", 6);
    chk("pend_count", 8'(n_done - base), 8'd2);
    step();
    chk("pend_idle", 8'(busy), 8'h0);

    // same-cycle write and boundary
    write(3'b100, 1'b0);
    q.push_back(4'b0100);
    step();
    write(3'b110, 1'b0);
    div_en = 1'b1;
    q.push_back(4'b0110);
    step();
    wr_req = 1'b0;
    div_en = 1'b0;
    chk("coll_first", 8'(div_sel), 8'h4);
    wait_done("coll_done1", 6);
    step();
    chk("coll_wait_busy", 8'(busy), 8'h1);
    div_en = 1'b1;
    step();
    div_en = 1'b0;
    chk("coll_second", 8'(div_sel), 8'h6);
    wait_done("coll_done2", 6);
    step();

    // boundary timeout
    write(3'b111, 1'b0);
    q.push_back(4'b0111);
    step();
    wr_req = 1'b0;
    for (int i = 0; i < 31; i++) step();
    chk("tmo_sel_t32", 8'(div_sel), 8'h6);
    chk("tmo_err_t32", 8'(tmo_err), 8'h0);
    step();
    chk("tmo_sel_t33", 8'(div_sel), 8'h7);
    chk("tmo_err_t33", 8'(tmo_err), 8'h1);
    wait_done("tmo_done", 6);
    step();
    step();
    chk("tmo_sticky", 8'(tmo_err), 8'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("tmo_cleared", 8'(tmo_err), 8'h0);

    // reset while in HOLD with a pending value
    write(3'b101, 1'b0);
    step();
    write(3'b100, 1'b0);
    step();
    wr_req = 1'b0;
    div_en = 1'b1;
    step();
    div_en = 1'b0;
    chk("mrst_applied", 8'(div_sel), 8'h5);
    base = n_done;
    rst = 1'b1;
    #1;
    chk("mrst_sel", 8'(div_sel), 8'h0);
    chk("mrst_busy", 8'(busy), 8'h0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("mrst_no_done", 8'(n_done - base), 8'd0);
    chk("mrst_sel_end", 8'(div_sel), 8'h0);
    chk("mrst_busy_end", 8'(busy), 8'h0);
    chk("queue_empty", 8'(q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
